// File: rtl/cm138_scan_driver.sv
// Registered select/enable sequencer for a CM138 3-to-8 decoder: setup, strobe, hold per address.
// Define SCAN_WRAP_EN to make scan mode wrap from address 7 back to 0 until stop is handled.
module cm138_scan_driver #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [2:0] addr_in,
    input  logic       stop,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] addr, addr_nxt;
    logic       mode_q, mode_nxt;
    logic       stop_pending, stop_nxt;
    logic       done_nxt;
    logic       en_nxt;
    logic       busy_nxt;
    logic       phase_end;

    assign phase_end = (cnt == 4'd0);

    // State register; outputs are registered from the next-state decode so they switch with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr         <= 3'd0;
            mode_q       <= 1'b0;
            stop_pending <= 1'b0;
            a            <= 1'b0;
            b            <= 1'b0;
            c            <= 1'b0;
            d            <= 1'b0;
            e            <= 1'b1;
            f            <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            addr         <= addr_nxt;
            mode_q       <= mode_nxt;
            stop_pending <= stop_nxt;
            a            <= addr_nxt[0];
            b            <= addr_nxt[1];
            c            <= addr_nxt[2];
            d            <= en_nxt;
            e            <= ~en_nxt;
            f            <= ~en_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
        addr_nxt  = addr;
        mode_nxt  = mode_q;
        stop_nxt  = stop_pending | (stop & mode_q);
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = 4'd0;
                stop_nxt = 1'b0;
                if (start) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                    mode_nxt  = mode;
                    addr_nxt  = mode ? 3'd0 : addr_in;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LD;
                end
            end
            STROBE: begin
                if (phase_end) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    if (!mode_q || stop_pending) begin
                        state_nxt = IDLE;
                        stop_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else if (addr != 3'd7) begin
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_LD;
                        addr_nxt  = addr + 3'd1;
                    end else begin
`ifdef SCAN_WRAP_EN
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_LD;
                        addr_nxt  = 3'd0;
`else
                        state_nxt = IDLE;
                        stop_nxt  = 1'b0;
                        done_nxt  = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        en_nxt   = (state_nxt == STROBE);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule
